data_wb_bus_if: RTL and testbench

//  Data-side Wishbone B3 classic master. Sits directly downstream of the MEM stage.

---
 rtl/data_wb_bus_if_if.sv | 22 ++
 rtl/data_wb_bus_if.sv | 140 ++++++++++++++
 tb/tb_data_wb_bus_if.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_wb_bus_if_if.sv
// Wishbone B3 classic bus bundle between the data-side master and its slave.
// dat_w carries store data towards the slave, dat_r carries load data back.
interface data_wb_bus_if_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  ack, dat_r
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output ack, dat_r
    );
endinterface

// File: rtl/data_wb_bus_if.sv
// Data-side Wishbone B3 classic master. Turns each MEM-stage access request into
// one Wishbone cycle, stalls the pipeline until the slave acknowledges, returns
// load data, and aborts on pipeline flush or on a bus timeout.
module data_wb_bus_if #(
    parameter int TIMEOUT = 255,   // BUSY cycles without ack before abort, 0 = never
    parameter int CNT_W   = 8      // timeout counter width, 2**CNT_W > TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall_i,
    input  logic                   flush_i,
    input  logic                   cpu_ce_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic                   cpu_we_i,
    input  logic [3:0]             cpu_sel_i,
    input  logic [31:0]            cpu_data_i,
    output logic [31:0]            cpu_data_o,
    output logic                   stallreq,
    output logic                   bus_err_o,
    data_wb_bus_if_if.master       wb
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_STALL
    } state_t;

    state_t            state;
    logic [31:0]       rd_buf;
    logic [CNT_W-1:0]  cnt;
    logic              mem_stall;
    logic              timeout_hit;

    // Only the MEM-stage bit of the stall vector matters to this block.
    logic unused_stall;
    assign unused_stall = ^{stall_i[5], stall_i[3:0]};

    assign mem_stall = stall_i[4];

    // Last permitted BUSY cycle with no acknowledge from the slave.
    assign timeout_hit = (TIMEOUT > 0) && (state == BUSY) && !wb.ack
                         && (cnt == CNT_W'(TIMEOUT - 1));

    // Bus FSM: launches, holds and terminates Wishbone cycles; all bus outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: state and registered outputs use non-blocking assignments so every
        // branch sees the pre-edge values, independent of statement order.
        if (rst) begin
            state     <= IDLE;
            wb.cyc    <= 1'b0;
            wb.stb    <= 1'b0;
            wb.we     <= 1'b0;
            wb.sel    <= 4'b0;
            wb.adr    <= 32'b0;
            wb.dat_w  <= 32'b0;
            // NOTE: rd_buf is a single register, not a memory, so clearing it
            // on reset is cheap and keeps stale load data from leaking out.
            rd_buf    <= 32'b0;
            cnt       <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            if (flush_i) begin
                // Flush wins over everything, including an ack in this cycle.
                wb.cyc <= 1'b0;
                wb.stb <= 1'b0;
                state  <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cpu_ce_i) begin
                            wb.adr   <= cpu_addr_i;
                            wb.we    <= cpu_we_i;
                            wb.sel   <= cpu_sel_i;
                            wb.dat_w <= cpu_data_i;
                            wb.cyc   <= 1'b1;
                            wb.stb   <= 1'b1;
                            cnt      <= '0;
                            state    <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (wb.ack) begin
                            wb.cyc <= 1'b0;
                            wb.stb <= 1'b0;
                            wb.we  <= 1'b0;
                            rd_buf <= wb.dat_r;
                            state  <= mem_stall ? WAIT_STALL : IDLE;
                        end else if (timeout_hit) begin
                            wb.cyc    <= 1'b0;
                            wb.stb    <= 1'b0;
                            bus_err_o <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_STALL: begin
                        // Hold the returned word until MEM is allowed to consume it.
                        if (!mem_stall) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Stall request and load data returned to the MEM stage in the current cycle.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        stallreq   = 1'b0;
        cpu_data_o = 32'b0;
        if (!rst && !flush_i) begin
            unique case (state)
                IDLE: begin
                    stallreq = cpu_ce_i;
                end
                BUSY: begin
                    if (wb.ack) begin
                        cpu_data_o = wb.dat_r;
                    end else begin
                        // The abort cycle releases the pipeline with zero data.
                        stallreq = !timeout_hit;
                    end
                end
                WAIT_STALL: begin
                    cpu_data_o = rd_buf;
                end
                default: begin
                    stallreq   = 1'b0;
                    cpu_data_o = 32'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_wb_bus_if.sv
// Directed bench for data_wb_bus_if: stimulus pushes expected bus requests,
// completions and bus errors into queues; a monitor pops and compares them when
// the DUT shows the matching event. Inline checks cover stall/reset behaviour.
module tb_data_wb_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        ce;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] cpu_data;
    logic        stallreq;
    logic        bus_err;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } req_t;

    req_t        req_q[$];
    logic [31:0] cpl_q[$];
    bit          err_q[$];

    always #5 clk = ~clk;

    data_wb_bus_if_if wb();

    data_wb_bus_if #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .flush_i    (flush),
        .cpu_ce_i   (ce),
        .cpu_addr_i (addr),
        .cpu_we_i   (we),
        .cpu_sel_i  (sel),
        .cpu_data_i (wdata),
        .cpu_data_o (cpu_data),
        .stallreq   (stallreq),
        .bus_err_o  (bus_err),
        .wb         (wb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d);
        addr  = a;
        we    = w;
        sel   = s;
        wdata = d;
        ce    = 1'b1;
        req_q.push_back('{adr: a, sel: s, we: w, dat: d});
    endtask

    // Monitor: compares bus requests, completions and error pulses against the queues.
    initial begin
        logic prev_cyc;
        req_t cur;
        req_t exp_r;
        prev_cyc = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (wb.cyc === 1'b1 && !prev_cyc) begin
                cur = '{adr: wb.adr, sel: wb.sel, we: wb.we, dat: wb.dat_w};
                if (req_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_cycle: got adr %h expected no cycle", wb.adr);
                end else begin
                    exp_r = req_q.pop_front();
                    check("req_adr", cur.adr, exp_r.adr);
                    check("req_sel", {28'b0, cur.sel}, {28'b0, exp_r.sel});
                    check("req_we",  {31'b0, cur.we},  {31'b0, exp_r.we});
                    check("req_dat", cur.dat, exp_r.dat);
                end
            end else if (wb.cyc === 1'b1) begin
                check("bus_hold", {31'b0, ({wb.adr, wb.sel, wb.we, wb.dat_w} == cur)}, 32'd1);
            end
            if (!rst && !flush && wb.cyc === 1'b1 && wb.ack) begin
                if (cpl_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_completion: got data %h expected none", cpu_data);
                end else begin
                    check("cpl_data", cpu_data, cpl_q.pop_front());
                    check("cpl_stallreq", {31'b0, stallreq}, 32'd0);
                end
            end
            if (bus_err === 1'b1) begin
                if (err_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_bus_err: got 1 expected 0");
                end else begin
                    void'(err_q.pop_front());
                    check("err_data", cpu_data, 32'd0);
                    check("err_cyc", {31'b0, wb.cyc}, 32'd0);
                end
            end
            prev_cyc = (wb.cyc === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        stall    = 6'b0;
        flush    = 1'b0;
        ce       = 1'b1;
        addr     = 32'h0;
        we       = 1'b0;
        sel      = 4'h0;
        wdata    = 32'h0;
        wb.ack   = 1'b0;
        wb.dat_r = 32'h0;

        // Reset state; comb outputs forced to 0 while rst is high even with ce=1.
        tick();
        tick();
        @(negedge clk);
        check("rst_cyc",      {31'b0, wb.cyc}, 32'd0);
        check("rst_stb",      {31'b0, wb.stb}, 32'd0);
        check("rst_we",       {31'b0, wb.we},  32'd0);
        check("rst_sel",      {28'b0, wb.sel}, 32'd0);
        check("rst_adr",      wb.adr,          32'd0);
        check("rst_dat",      wb.dat_w,        32'd0);
        check("rst_bus_err",  {31'b0, bus_err},  32'd0);
        check("rst_stallreq", {31'b0, stallreq}, 32'd0);
        check("rst_cpu_data", cpu_data,          32'd0);
        tick();
        rst = 1'b0;
        ce  = 1'b0;

        // 1: load, ack on first BUSY cycle.
        tick();
        request(32'h0000_0100, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        check("t1_req_stallreq", {31'b0, stallreq}, 32'd1);
        check("t1_req_cyc",      {31'b0, wb.cyc},   32'd0);
        check("t1_req_data",     cpu_data,          32'd0);
        tick();
        wb.ack   = 1'b1;
        wb.dat_r = 32'hDEAD_BEEF;
        cpl_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_ack_stallreq", {31'b0, stallreq}, 32'd0);
        tick();
        wb.ack   = 1'b0;
        wb.dat_r = 32'h0;
        ce       = 1'b0;
        @(negedge clk);
        check("t1_after_cyc",  {31'b0, wb.cyc}, 32'd0);
        check("t1_after_data", cpu_data,        32'd0);

        // 2: store with three wait states, ack on the last permitted BUSY cycle.
        tick();
        request(32'h8000_1004, 1'b1, 4'b0011, 32'h0000_1234);
        @(negedge clk);
        check("t2_req_stallreq", {31'b0, stallreq}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t2_wait_stallreq", {31'b0, stallreq}, 32'd1);
            check("t2_wait_data",     cpu_data,          32'd0);
            check("t2_wait_we",       {31'b0, wb.we},    32'd1);
        end
        tick();
        wb.ack   = 1'b1;
        wb.dat_r = 32'hCAFE_F00D;
        cpl_q.push_back(32'hCAFE_F00D);
        @(negedge clk);
        check("t2_ack_stallreq", {31'b0, stallreq}, 32'd0);
        tick();
        wb.ack = 1'b0;
        ce     = 1'b0;
        @(negedge clk);
        check("t2_after_cyc", {31'b0, wb.cyc}, 32'd0);
        check("t2_after_we",  {31'b0, wb.we},  32'd0);

        // 3: load acked while MEM stalled; data held in WAIT_STALL, held ce ignored.
        tick();
        request(32'h0000_0200, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        check("t3_req_stallreq", {31'b0, stallreq}, 32'd1);
        tick();
        wb.ack   = 1'b1;
        wb.dat_r = 32'hA5A5_5A5A;
        stall    = 6'b01_0000;
        cpl_q.push_back(32'hA5A5_5A5A);
        @(negedge clk);
        check("t3_ack_stallreq", {31'b0, stallreq}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb.ack   = 1'b0;
            wb.dat_r = 32'h1111_1111;
            @(negedge clk);
            check("t3_hold_data",     cpu_data,          32'hA5A5_5A5A);
            check("t3_hold_stallreq", {31'b0, stallreq}, 32'd0);
            check("t3_hold_cyc",      {31'b0, wb.cyc},   32'd0);
        end
        tick();
        stall = 6'b0;
        ce    = 1'b0;
        @(negedge clk);
        check("t3_release_data", cpu_data, 32'hA5A5_5A5A);
        tick();
        @(negedge clk);
        check("t3_idle_data", cpu_data,        32'd0);
        check("t3_idle_cyc",  {31'b0, wb.cyc}, 32'd0);

        // 4: flush on second BUSY cycle, then a stray ack.
        tick();
        request(32'h0000_0300, 1'b0, 4'hF, 32'h0);
        tick();
        @(negedge clk);
        check("t4_busy1_stallreq", {31'b0, stallreq}, 32'd1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("t4_flush_stallreq", {31'b0, stallreq}, 32'd0);
        check("t4_flush_data",     cpu_data,          32'd0);
        tick();
        flush = 1'b0;
        ce    = 1'b0;
        @(negedge clk);
        check("t4_after_cyc", {31'b0, wb.cyc}, 32'd0);
        check("t4_after_stb", {31'b0, wb.stb}, 32'd0);
        tick();
        wb.ack   = 1'b1;
        wb.dat_r = 32'hBAD0_BAD0;
        @(negedge clk);
        check("t4_stray_data",     cpu_data,          32'd0);
        check("t4_stray_stallreq", {31'b0, stallreq}, 32'd0);
        check("t4_stray_cyc",      {31'b0, wb.cyc},   32'd0);
        tick();
        wb.ack = 1'b0;

        // 5: slave never acks; abort after four BUSY cycles.
        tick();
        request(32'h0000_0400, 1'b0, 4'hF, 32'h0);
        err_q.push_back(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t5_busy_stallreq", {31'b0, stallreq}, 32'd1);
        end
        tick();
        @(negedge clk);
        check("t5_abort_stallreq", {31'b0, stallreq}, 32'd0);
        check("t5_abort_data",     cpu_data,          32'd0);
        check("t5_abort_cyc",      {31'b0, wb.cyc},   32'd1);
        tick();
        ce = 1'b0;
        @(negedge clk);
        check("t5_err_cyc",   {31'b0, wb.cyc},  32'd0);
        check("t5_err_pulse", {31'b0, bus_err}, 32'd1);
        tick();
        @(negedge clk);
        check("t5_err_clear", {31'b0, bus_err}, 32'd0);

        // 6: reset in the middle of a store, late ack, then a normal load.
        tick();
        request(32'h0000_0500, 1'b1, 4'b1100, 32'h0000_0077);
        tick();
        @(negedge clk);
        check("t6_busy_stallreq", {31'b0, stallreq}, 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_stallreq", {31'b0, stallreq}, 32'd0);
        check("t6_rst_data",     cpu_data,          32'd0);
        tick();
        rst = 1'b0;
        ce  = 1'b0;
        @(negedge clk);
        check("t6_cyc", {31'b0, wb.cyc},   32'd0);
        check("t6_stb", {31'b0, wb.stb},   32'd0);
        check("t6_we",  {31'b0, wb.we},    32'd0);
        check("t6_sel", {28'b0, wb.sel},   32'd0);
        check("t6_adr", wb.adr,            32'd0);
        check("t6_dat", wb.dat_w,          32'd0);
        check("t6_err", {31'b0, bus_err},  32'd0);
        tick();
        wb.ack   = 1'b1;
        wb.dat_r = 32'h5555_5555;
        @(negedge clk);
        check("t6_late_ack_data", cpu_data,        32'd0);
        check("t6_late_ack_cyc",  {31'b0, wb.cyc}, 32'd0);
        tick();
        wb.ack = 1'b0;
        request(32'h0000_0600, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        check("t6_new_req_stallreq", {31'b0, stallreq}, 32'd1);
        tick();
        wb.ack   = 1'b1;
        wb.dat_r = 32'h0BAD_F00D;
        cpl_q.push_back(32'h0BAD_F00D);
        @(negedge clk);
        check("t6_new_ack_stallreq", {31'b0, stallreq}, 32'd0);
        tick();
        wb.ack = 1'b0;
        ce     = 1'b0;
        @(negedge clk);
        check("t6_new_after_cyc", {31'b0, wb.cyc}, 32'd0);

        tick();
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("cpl_q_drained", 32'(cpl_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
